// File: rtl/cnt_timer_ctrl.sv
// Interval timer controller for an external loadable up-counter: prescaled enable, periodic/one-shot reload.
// Optional sticky interrupt flag when TIMER_CTRL_IRQ_EN is defined (adds irq_clr_i / irq_o).
module cnt_timer_ctrl #(
  parameter int WIDTH     = 8,
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 oneshot_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [WIDTH-1:0]     start_val_i,
  input  logic [WIDTH-1:0]     end_val_i,
  input  logic [WIDTH-1:0]     cnt_i,
`ifdef TIMER_CTRL_IRQ_EN
  input  logic                 irq_clr_i,
  output logic                 irq_o,
`endif
  output logic                 ld_o,
  output logic [WIDTH-1:0]     ld_cnt_o,
  output logic                 ena_cnt_o,
  output logic                 tick_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [PSC_WIDTH-1:0] psc_cnt, psc_q;
  logic [WIDTH-1:0]     start_q, end_q;
  logic                 oneshot_q;
  logic                 pt, term;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      psc_cnt   <= '0;
      psc_q     <= '0;
      start_q   <= '0;
      end_q     <= '0;
      oneshot_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!stop_i && start_i) begin
        psc_q     <= psc_i;
        start_q   <= start_val_i;
        end_q     <= end_val_i;
        oneshot_q <= oneshot_i;
      end
      // Prescaler only advances while running undisturbed; any start/stop re-phases it.
      if (state == RUN && !stop_i && !start_i)
        psc_cnt <= pt ? '0 : psc_cnt + 1'b1;
      else
        psc_cnt <= '0;
    end
  end

  always_comb begin
    pt   = (state == RUN) && (psc_cnt == psc_q);
    term = pt && (cnt_i == end_q);

    ld_o      = (state == LOAD) | (term & ~oneshot_q);
    ld_cnt_o  = start_q;
    ena_cnt_o = pt & ~term;
    tick_o    = term;
    busy_o    = (state == LOAD) || (state == RUN);
    done_o    = (state == DONE);

    state_nxt = state;
    if (stop_i)
      state_nxt = IDLE;
    else if (start_i)
      state_nxt = LOAD;
    else begin
      case (state)
        LOAD:    state_nxt = RUN;
        RUN:     if (term && oneshot_q) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

`ifdef TIMER_CTRL_IRQ_EN
  // Set beats clear so a tick coinciding with an acknowledge is never lost.
  always_ff @(posedge clk_i) begin
    if (rst_i)          irq_o <= 1'b0;
    else if (term)      irq_o <= 1'b1;
    else if (irq_clr_i) irq_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_cnt_timer_ctrl.sv
// Randomized scoreboard bench for cnt_timer_ctrl with an attached up-counter model.
// Expected ticks are scheduled from the period formula when a start is issued; a monitor pops and compares.
module tb_cnt_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, oneshot;
  logic [7:0] psc, sv, ev, cnt;
  logic       ld, ena, tick, busy, done;
  logic [7:0] ld_cnt;
`ifdef TIMER_CTRL_IRQ_EN
  logic       irq_clr, irq;
  logic       irq_pred = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       ld;
  } exp_t;
  exp_t q[$];

  cnt_timer_ctrl #(.WIDTH(8), .PSC_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .oneshot_i(oneshot),
    .psc_i(psc), .start_val_i(sv), .end_val_i(ev), .cnt_i(cnt),
`ifdef TIMER_CTRL_IRQ_EN
    .irq_clr_i(irq_clr), .irq_o(irq),
`endif
    .ld_o(ld), .ld_cnt_o(ld_cnt), .ena_cnt_o(ena), .tick_o(tick),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The loadable up-counter the controller drives.
  initial cnt = 8'h00;
  always @(posedge clk) begin
    if (ld)       cnt <= ld_cnt;
    else if (ena) cnt <= cnt + 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: flush missed ticks, then match any presented tick against the queue head.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missed_tick", 32'(q[0].cyc), 32'(cyc));
      void'(q.pop_front());
    end
    if (tick) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("tick_cnt", 32'(cnt), 32'(q[0].cnt));
        chk("tick_ld", 32'(ld), 32'(q[0].ld));
        void'(q.pop_front());
      end else
        chk("unexpected_tick", 32'(cyc), 32'(q.size() > 0 ? q[0].cyc : -1));
    end
    if (ld && ena) chk("ld_ena_excl", 32'({ld, ena}), 32'b10);
`ifdef TIMER_CTRL_IRQ_EN
    chk("irq", 32'(irq), 32'(irq_pred));
    irq_pred = rst ? 1'b0 : (tick ? 1'b1 : (irq_clr ? 1'b0 : irq_pred));
`endif
  end

`ifdef TIMER_CTRL_IRQ_EN
  initial begin
    irq_clr = 1'b0;
    forever begin
      @(posedge clk); #1;
      irq_clr = ($urandom_range(0, 3) == 0);
    end
  end
`endif

  // Start a run sampled at the next edge E; the next control edge is E+len.
  task automatic issue_start(input bit os, input logic [7:0] p, input logic [7:0] s,
                             input logic [7:0] e, input int len);
    int         E, N, P;
    logic [7:0] d;
    oneshot = os; psc = p; sv = s; ev = e;
    start = 1'b1;
    E = cyc + 1;
    d = e - s;
    N = int'(d) + 1;
    P = N * (int'(p) + 1);
    for (int n = 1; n * P <= len - 1; n++) begin
      q.push_back('{cyc: E + n * P, cnt: e, ld: !os});
      if (os) break;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_ld", 32'(ld), 32'd1);
    chk("load_ld_cnt", 32'(ld_cnt), 32'(s));
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_ena", 32'(ena), 32'd0);
    repeat (len - 1) @(posedge clk);
    #1;
    if (os && (len - 1 >= P + 1)) begin
      chk("done_done", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_cnt_frozen", 32'(cnt), 32'(e));
      chk("done_ena", 32'(ena), 32'd0);
    end
  endtask

  task automatic do_abort(input bit use_rst, input bit with_start);
    if (use_rst) rst = 1'b1;
    else begin
      stop = 1'b1;
      start = with_start;
      sv = 8'($urandom);
    end
    @(posedge clk); #1;
    for (int i = 0; i < (use_rst ? 2 : 1); i++) begin
      chk("abort_ld", 32'(ld), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_ena", 32'(ena), 32'd0);
      chk("abort_tick", 32'(tick), 32'd0);
      if (use_rst) begin
        chk("rst_ld_cnt", 32'(ld_cnt), 32'd0);
        if (i == 0) begin @(posedge clk); #1; end
      end
    end
    rst = 1'b0; stop = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    psc = '0; sv = '0; ev = '0;
    @(posedge clk); #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_outs", 32'({ld, ena, tick, done}), 32'd0);
    @(posedge clk); #1;
    chk("reset_ld_cnt", 32'(ld_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue_start(1'b0, 8'd0, 8'd3,   8'd5,   10);  // periodic, period 3
    issue_start(1'b1, 8'd2, 8'd0,   8'd1,   12);  // one-shot prescaled, tick at LOAD+6
    issue_start(1'b0, 8'd0, 8'hFE,  8'h01,  13);  // wrap through 0, period 4
    issue_start(1'b0, 8'd1, 8'd10,  8'd12,  9);   // restart in RUN with start=10
    do_abort(1'b0, 1'b1);                          // stop and start together
    issue_start(1'b0, 8'd1, 8'd5,   8'd9,   15);
    do_abort(1'b1, 1'b0);                          // mid-run reset

    for (int i = 0; i < 40; i++) begin
      logic [7:0] s, e;
      s = 8'($urandom);
      e = ($urandom_range(0, 7) == 0) ? 8'($urandom) : s + 8'($urandom_range(0, 5));
      issue_start(1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 3)), s, e,
                  $urandom_range(2, 40));
      if ($urandom_range(0, 3) == 0) do_abort(1'b0, 1'($urandom_range(0, 1)));
    end
    do_abort(1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      chk("leftover_tick", 32'(q[0].cyc), 32'(-1));
      void'(q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
